// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - serial frame loader that commits a verified 8-bit routing word
module cfg_loader #(
    parameter logic [7:0] SYNC_WORD   = 8'hA5,
    parameter logic [7:0] DEFAULT_MAP = 8'hE4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic       cfg_abort,
    input  logic       cfg_valid,
    input  logic       cfg_data,
    output logic       cfg_ready,
    output logic [7:0] bitfile,
    output logic       cfg_done,
    output logic       cfg_error,
    output logic [1:0] err_code,
    output logic       cfg_busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_CHECK   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_ABORT = 2'b00;
    localparam logic [1:0] ERR_SYNC  = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;
    localparam logic [1:0] ERR_MAP   = 2'b11;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sreg_q, sreg_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] creg_q, creg_d;
    logic [7:0] bitfile_q, bitfile_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [1:0] code_q, code_d;

    logic       accept;
    logic       last_bit;
    logic       map_legal;
    logic [7:0] sync_word;
    logic [7:0] csum_word;

    // A legal map sends each of the four sources to a distinct destination.
    assign map_legal = (shadow_q[1:0] != shadow_q[3:2]) && (shadow_q[1:0] != shadow_q[5:4]) &&
                       (shadow_q[1:0] != shadow_q[7:6]) && (shadow_q[3:2] != shadow_q[5:4]) &&
                       (shadow_q[3:2] != shadow_q[7:6]) && (shadow_q[5:4] != shadow_q[7:6]);

    assign cfg_ready = (state_q == S_SYNC) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    assign cfg_busy  = (state_q != S_IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign last_bit  = (cnt_q == 3'd7);
    assign sync_word = {sreg_q[6:0], cfg_data};
    assign csum_word = {creg_q[6:0], cfg_data};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        shadow_d  = shadow_q;
        creg_d    = creg_q;
        bitfile_d = bitfile_q;
        done_d    = done_q;
        error_d   = error_q;
        code_d    = code_q;

        if (state_q == S_IDLE) begin
            if (cfg_start && !cfg_abort) begin
                state_d = S_SYNC;
                cnt_d   = 3'd0;
                done_d  = 1'b0;
                error_d = 1'b0;
                code_d  = ERR_ABORT;
            end
        end else if (cfg_abort) begin
            // Abort wins over both bit acceptance and the commit.
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            done_d  = 1'b0;
            error_d = 1'b1;
            code_d  = ERR_ABORT;
        end else begin
            case (state_q)
                S_SYNC: begin
                    if (accept) begin
                        cnt_d  = cnt_q + 3'd1;
                        sreg_d = sync_word;
                        if (last_bit) begin
                            if (sync_word == SYNC_WORD) begin
                                state_d = S_PAYLOAD;
                            end else begin
                                state_d = S_IDLE;
                                error_d = 1'b1;
                                code_d  = ERR_SYNC;
                            end
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        cnt_d    = cnt_q + 3'd1;
                        shadow_d = {shadow_q[6:0], cfg_data};
                        if (last_bit) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        cnt_d  = cnt_q + 3'd1;
                        creg_d = csum_word;
                        if (last_bit) begin
                            if (csum_word == ~shadow_q) begin
                                state_d = S_CHECK;
                            end else begin
                                state_d = S_IDLE;
                                error_d = 1'b1;
                                code_d  = ERR_CSUM;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (map_legal) begin
                        bitfile_d = shadow_q;
                        done_d    = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        code_d  = ERR_MAP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            sreg_q    <= 8'h00;
            shadow_q  <= 8'h00;
            creg_q    <= 8'h00;
            bitfile_q <= DEFAULT_MAP;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= ERR_ABORT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            shadow_q  <= shadow_d;
            creg_q    <= creg_d;
            bitfile_q <= bitfile_d;
            done_q    <= done_d;
            error_q   <= error_d;
            code_q    <= code_d;
        end
    end

    assign bitfile   = bitfile_q;
    assign cfg_done  = done_q;
    assign cfg_error = error_q;
    assign err_code  = code_q;

endmodule

// File: doc/cfg_loader.md
# cfg_loader

Serial configuration loader for the four-CLB adder fabric. It receives a framed routing word over a 1-bit valid/ready stream and validates the frame (sync word, checksum, routing legality). Only then does it commit the 8-bit routing configuration that drives the routing channel's `BitFile` input. The committed word only changes atomically after a fully verified frame, so the routing channel never sees a partial or illegal mapping.

## Interface
Parameters:
- `SYNC_WORD`, default `8'hA5`: frame header value.
- `DEFAULT_MAP`, default `8'hE4`: routing word loaded at reset. It is the identity map: A=00, B=01, C=10, D=11.

Ports:
- `clk`, input, 1: sole clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cfg_start`, input, 1: single-cycle request to begin loading a frame; honoured only in IDLE.
- `cfg_abort`, input, 1: abandons the load in progress.
- `cfg_valid`, input, 1: `cfg_data` is valid this cycle.
- `cfg_data`, input, 1: serial frame bit, MSB first.
- `cfg_ready`, output, 1: loader accepts a bit this cycle.
- `bitfile`, output, 8: committed routing word, fed to the routing channel's `BitFile`.
- `cfg_done`, output, 1: last frame committed successfully; level signal.
- `cfg_error`, output, 1: last load failed; level signal.
- `err_code`, output, 2: failure cause. 00 = abort, 01 = sync mismatch, 10 = checksum mismatch, 11 = illegal map.
- `cfg_busy`, output, 1: high when state ≠ IDLE.

## Operation
- Frame is 24 bits, MSB first, in three fields: sync byte, payload byte (routing word), checksum byte.
- Checksum rule: checksum = bitwise NOT of payload.
- A bit is accepted on a cycle where `cfg_valid & cfg_ready`. `cfg_valid` may drop at any time; there is no timeout.
- A 3-bit bit counter counts 0–7 within each field and wraps to 0 at every field boundary.

FSM states:
- IDLE
  - `cfg_ready`=0.
  - `cfg_start`=1 → SYNC. On entry: clear `cfg_done`, `cfg_error`, `err_code`; zero the counter.
- SYNC
  - `cfg_ready`=1; shift bits into the sync register.
  - On the 8th accepted bit, compare {sreg[6:0], `cfg_data`} with `SYNC_WORD`.
  - Match → PAYLOAD. Mismatch → IDLE with `cfg_error`=1, code 01.
- PAYLOAD
  - `cfg_ready`=1; shift bits into the shadow register.
  - After the 8th bit → CSUM.
- CSUM
  - `cfg_ready`=1; shift bits into the checksum register.
  - On the 8th bit, compare {creg[6:0], `cfg_data`} with ~shadow.
  - Equal → CHECK. Not equal → IDLE, error code 10.
- CHECK
  - Single cycle, `cfg_ready`=0.
  - Legal map: the four 2-bit fields shadow[1:0], [3:2], [5:4], [7:6] are pairwise distinct.
  - Legal → `bitfile` ← shadow, `cfg_done` ← 1, → IDLE.
  - Illegal → IDLE, error code 11.

Boundary rules:
- `cfg_abort` in SYNC, PAYLOAD, CSUM or CHECK → IDLE, `cfg_error`=1, code 00.
  - Abort has priority over bit acceptance and over the CHECK commit.
  - Abort in IDLE is ignored, including when it coincides with `cfg_start` (no load starts).
- `cfg_start` outside IDLE is ignored.
- `bitfile` never changes except in a CHECK cycle with a legal map, or on reset. On any failure it keeps its previous value.
- `cfg_done` and `cfg_error` are never high together. Both hold until the next accepted `cfg_start`.
- Reset mid-load discards all partial state immediately.

## Timing
- Reset values:
  - state IDLE.
  - `bitfile`=`DEFAULT_MAP`.
  - `cfg_done`=0, `cfg_error`=0, `err_code`=00.
  - `cfg_busy`=0, `cfg_ready`=0.
  - Shift registers and counter all 0.
- `cfg_start` high in cycle 0 → state SYNC in cycle 1 → `cfg_ready` and `cfg_busy` high from cycle 1.
- With `cfg_valid` held high: bits are accepted in cycles 1–24, CHECK occurs in cycle 25, and the new `bitfile` plus `cfg_done`=1 are visible in cycle 26.
- Each idle `cfg_valid` cycle adds exactly one cycle of latency.
- A field failure on an 8th bit makes `cfg_error` visible and `cfg_ready`=0 in the next cycle.
- Abort in cycle n makes `cfg_error` visible and `cfg_busy`=0 in cycle n+1.
- All outputs are registered, except `cfg_ready` and `cfg_busy`, which are decoded from the state register only.

## Test plan
- Reset release → `bitfile`=E4; `cfg_done`, `cfg_error`, `cfg_busy` and `cfg_ready` all 0.
- `cfg_start`, then contiguous frame A5/1B/E4 → `bitfile`=1B and `cfg_done`=1 at cycle 26, `cfg_busy`=0.
- Frame A4/… → after 8th bit `cfg_error`=1, `err_code`=01, `bitfile` unchanged at E4; remaining bits are not accepted (`cfg_ready`=0).
- Frames A5/1B/E5 → code 10; A5/00/FF → code 11. In both cases `bitfile` unchanged.
- Frame A5/1B/E4 with `cfg_valid` toggling every other cycle → commit at cycle 50. A `cfg_start` pulse mid-frame is ignored.
- Abort after 12 bits → code 00, `bitfile` unchanged. Separately, `rst_n` low after 20 bits → all outputs return to their reset values asynchronously and the next full frame loads correctly.
